// File: rtl/led_matrix_pwm.sv
// Row-multiplexed LED matrix driver with per-LED PWM brightness,
// inter-row blanking and a double-buffered frame store.
module led_matrix_pwm #(
   parameter int ROWS     = 4,
   parameter int COLS     = 4,
   parameter int PWM_BITS = 4,
   parameter int DIV      = 32,
   parameter int BLANK    = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          enable,
   input  logic [ROWS*COLS*PWM_BITS-1:0] frame_in,
   input  logic                          load,
   output logic                          pending,
   output logic [ROWS-1:0]               aled,
   output logic [COLS-1:0]               kled_tri,
   output logic                          frame_start
);

   localparam int MAXL = 2**PWM_BITS - 1;
   localparam int SLOT = MAXL + BLANK;
   localparam int NB   = ROWS*COLS*PWM_BITS;
   localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int TW   = $clog2(SLOT);
   localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;

   localparam logic [PW-1:0] PRE_MAX  = PW'(DIV-1);
   localparam logic [TW-1:0] TICK_MAX = TW'(SLOT-1);
   localparam logic [TW-1:0] PWM_END  = TW'(MAXL);
   localparam logic [RW-1:0] ROW_MAX  = RW'(ROWS-1);

   logic [PW-1:0]   pre;
   logic [TW-1:0]   tick;
   logic [RW-1:0]   row;
   logic [NB-1:0]   active;
   logic [NB-1:0]   shadow;

   logic            tick_en;
   logic            tick_wrap;
   logic            frame_wrap;
   logic            swap;
   logic            pwm_phase;
   logic [ROWS-1:0] aled_d;
   logic [COLS-1:0] kled_d;

   always_comb begin
      tick_en    = enable && (pre == PRE_MAX);
      tick_wrap  = tick_en && (tick == TICK_MAX);
      frame_wrap = tick_wrap && (row == ROW_MAX);
      // while disabled nothing is shown, so a waiting image can go live at once
      swap       = pending && (frame_wrap || !enable);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre  <= '0;
         tick <= '0;
         row  <= '0;
      end else if (!enable) begin
         pre  <= '0;
         tick <= '0;
         row  <= '0;
      end else begin
         pre <= tick_en ? '0 : pre + 1'b1;
         if (tick_en)
            tick <= (tick == TICK_MAX) ? '0 : tick + 1'b1;
         if (tick_wrap)
            row <= (row == ROW_MAX) ? '0 : row + 1'b1;
      end
   end

   always_comb begin
      pwm_phase = (tick < PWM_END);
      aled_d    = '1;
      kled_d    = '0;
      if (pwm_phase)
         aled_d[row] = 1'b0;
      for (int c = 0; c < COLS; c++)
         kled_d[c] = pwm_phase &&
            (int'(tick) < int'(active[(c*ROWS + int'(row))*PWM_BITS +: PWM_BITS]));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         aled        <= '1;
         kled_tri    <= '0;
         frame_start <= 1'b0;
      end else if (!enable) begin
         aled        <= '1;
         kled_tri    <= '0;
         frame_start <= 1'b0;
      end else begin
         aled        <= aled_d;
         kled_tri    <= kled_d;
         frame_start <= (row == '0) && (tick == '0) && (pre == '0);
      end
   end

   // a load coinciding with a swap lands in shadow after the old image moves
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         active  <= '0;
         shadow  <= '0;
         pending <= 1'b0;
      end else begin
         if (swap)
            active <= shadow;
         if (load) begin
            shadow  <= frame_in;
            pending <= 1'b1;
         end else if (swap) begin
            pending <= 1'b0;
         end
      end
   end

endmodule
